// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver with a 4-entry receive FIFO and RTS flow control.
//
// Frame: 1 start bit, 8 data bits (LSB first), optional even parity,
// 1 stop bit.  Bits are sampled at the middle of each bit period.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after bit 7.  Without it the receiver is 8N1 and contains no parity logic.
//
// Parameters
//   CLK_FREQ  clock frequency in Hz
//   BAUD      line bit rate in bit/s
// Ports
//   clock      system clock, rising edge
//   n_rst      asynchronous active-low reset
//   RxD        serial line, idle high, asynchronous to clock
//   RTS        1 = peer may send (FIFO holds at most 2 bytes)
//   rx_data    FIFO head byte (registered)
//   rx_valid   rx_data holds a valid byte (FIFO not empty)
//   rx_ready   consumer takes rx_data this cycle
//   frame_err  one-cycle pulse: bad stop bit (or bad parity)
//   overrun    one-cycle pulse: byte dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       n_rst,
    input  logic       RxD,
    output logic       RTS,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rxs;
    logic            rxs_prev_q;
    logic [1:0]      fill_q;
    logic            start_edge;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            cnt_clr, shift_en, frame_done;
    logic            stop_good_q, stop_bad_q;
`ifdef UART_RX_PARITY_EN
    logic            par_sample;
    logic            par_err_q;
`endif

    // FIFO
    logic [7:0]      mem_q [4];
    logic [1:0]      rd_ptr_q, wr_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      rx_data_q, head_d;
    logic            pop, full, wr_en, drop;
    logic            rts_q, frame_err_q, overrun_q;

    assign rxs = sync_q[1];

    // The synchronizer resets to 1, so the first two samples after reset are
    // not real line levels.  Edge detection waits until rxs and rxs_prev both
    // come from RxD, so a line held low through reset never looks like a
    // falling edge.
    assign start_edge = (fill_q == 2'd3) && rxs_prev_q && !rxs;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state_q)
            IDLE: if (start_edge) begin
                state_d = START;
                cnt_clr = 1'b1;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_clr = 1'b1;
                state_d = rxs ? IDLE : DATA;   // high at mid start bit: glitch
            end
            DATA: if (cnt_q == DIV_LAST) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_q == DIV_LAST) begin
                cnt_clr    = 1'b1;
                par_sample = 1'b1;
                state_d    = STOP;
            end
`endif
            STOP: if (cnt_q == DIV_LAST) begin
                cnt_clr    = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;             // ready for a back-to-back start
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- line sampling datapath ----------------
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            sync_q      <= 2'b11;
            rxs_prev_q  <= 1'b1;
            fill_q      <= 2'd0;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            stop_good_q <= 1'b0;
            stop_bad_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], RxD};
            rxs_prev_q <= rxs;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;

            if (cnt_clr || state_q == IDLE) cnt_q <= '0;
            else                            cnt_q <= cnt_q + CW'(1);

            if (state_q == START)  bit_idx_q <= 3'd0;
            else if (shift_en)     bit_idx_q <= bit_idx_q + 3'd1;

            if (shift_en) shift_q <= {rxs, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
            if (par_sample) par_err_q <= (rxs != ^shift_q);
            stop_good_q <= frame_done && rxs && !par_err_q;
            stop_bad_q  <= frame_done && (!rxs || par_err_q);
`else
            stop_good_q <= frame_done && rxs;
            stop_bad_q  <= frame_done && !rxs;
`endif
        end
    end

    // ---------------- receive FIFO ----------------
    always_comb begin
        pop      = (count_q != 3'd0) && rx_ready;
        full     = (count_q == 3'd4);
        wr_en    = stop_good_q && (!full || pop);
        drop     = stop_good_q && full && !pop;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        // Next head: the byte being written this edge if it lands in the slot
        // that becomes the head, otherwise the stored entry.
        head_d = rx_data_q;
        if (count_d != 3'd0)
            head_d = (wr_en && rd_ptr_d == wr_ptr_q) ? shift_q : mem_q[rd_ptr_d];
    end

    // NOTE: storage has no reset; entries are only read once written, and
    // leaving the array unreset lets it map onto plain register/RAM cells.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            rx_data_q   <= 8'h00;
            rts_q       <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            count_q     <= count_d;
            rx_data_q   <= head_d;
            rts_q       <= (count_q <= 3'd2);   // lags the count by one cycle
            frame_err_q <= stop_bad_q;
            overrun_q   <= drop;
        end
    end

    assign rx_valid  = (count_q != 3'd0);
    assign rx_data   = rx_data_q;
    assign RTS       = rts_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
